// File: rtl/bus_cycle_arbiter.sv
// ---------------------------------------------------------------------------
// bus_cycle_arbiter : two-requester round-robin master for an 8088-style bus,
//                     sequencing T1/T2/T3/TW/T4 cycles with a wait timeout.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_cycle_arbiter #(
   parameter int ADDR_W   = 20,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              iom0,
   input  logic              iom1,
   input  logic              wr0,
   input  logic              wr1,
   input  logic [7:0]        wdata0,
   input  logic [7:0]        wdata1,
   input  logic              ready,
   input  logic [7:0]        data_in,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              ale,
   output logic              iom,
   output logic              rd_n,
   output logic              wr_n,
   output logic              den_n,
   output logic              data_oe,
   output logic [7:0]        data_out,
   output logic [1:0]        grant,
   output logic [1:0]        ack,
   output logic [7:0]        rdata,
   output logic              err
);

   localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam bit TIMEOUT_EN = (MAX_WAIT != 0);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_TW   = 3'd4,
      S_T4   = 3'd5
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             last;
   logic             wr_dir;
   logic [CNT_W-1:0] wait_cnt;

   logic             take_grant;
   logic             win;
   logic             capture;
   logic             timeout;
   logic             cnt_load;
   logic             cnt_inc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      take_grant = 1'b0;
      win        = 1'b0;
      capture    = 1'b0;
      timeout    = 1'b0;
      cnt_load   = 1'b0;
      cnt_inc    = 1'b0;
      ale        = 1'b0;
      rd_n       = 1'b1;
      wr_n       = 1'b1;
      den_n      = 1'b1;
      data_oe    = 1'b0;
      ack        = 2'b00;

      case (state)
         S_IDLE: begin
            if (req != 2'b00) begin
               take_grant = 1'b1;
               // Contention goes to whoever did not win last time.
               win        = (req == 2'b11) ? ~last : req[1];
               state_next = S_T1;
            end
         end
         S_T1: begin
            ale        = 1'b1;
            state_next = S_T2;
         end
         S_T2: begin
            den_n      = 1'b0;
            rd_n       = wr_dir;
            wr_n       = ~wr_dir;
            data_oe    = wr_dir;
            state_next = S_T3;
         end
         S_T3: begin
            den_n   = 1'b0;
            rd_n    = wr_dir;
            wr_n    = ~wr_dir;
            data_oe = wr_dir;
            if (ready) begin
               capture    = ~wr_dir;
               state_next = S_T4;
            end else begin
               cnt_load   = 1'b1;
               state_next = S_TW;
            end
         end
         S_TW: begin
            den_n   = 1'b0;
            rd_n    = wr_dir;
            wr_n    = ~wr_dir;
            data_oe = wr_dir;
            if (ready) begin
               capture    = ~wr_dir;
               state_next = S_T4;
            end else if (TIMEOUT_EN && (wait_cnt == WAIT_LIMIT)) begin
               timeout    = 1'b1;
               state_next = S_T4;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_T4: begin
            data_oe    = wr_dir;
            ack        = grant;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_addr <= '0;
         iom      <= 1'b0;
         data_out <= 8'h00;
         wr_dir   <= 1'b0;
         grant    <= 2'b00;
         last     <= 1'b1;
         rdata    <= 8'h00;
         err      <= 1'b0;
         wait_cnt <= '0;
      end else begin
         if (take_grant) begin
            bus_addr <= win ? addr1  : addr0;
            iom      <= win ? iom1   : iom0;
            data_out <= win ? wdata1 : wdata0;
            wr_dir   <= win ? wr1    : wr0;
            grant    <= win ? 2'b10  : 2'b01;
            last     <= win;
            err      <= 1'b0;
         end
         if (state == S_T4) begin
            grant <= 2'b00;
         end
         if (capture) begin
            rdata <= data_in;
         end
         if (timeout) begin
            err <= 1'b1;
         end
         // Saturating wait counter: it must never wrap back under the limit.
         if (cnt_load) begin
            wait_cnt <= CNT_W'(1);
         end else if (cnt_inc && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bus_cycle_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_cycle_arbiter : directed self-checking bench for bus_cycle_arbiter.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bus_cycle_arbiter;

   localparam int ADDR_W   = 20;
   localparam int MAX_WAIT = 4;

   logic              clk;
   logic              reset;
   logic [1:0]        req;
   logic [ADDR_W-1:0] addr0, addr1;
   logic              iom0, iom1, wr0, wr1;
   logic [7:0]        wdata0, wdata1;
   logic              ready;
   logic [7:0]        data_in;
   logic [ADDR_W-1:0] bus_addr;
   logic              ale, iom, rd_n, wr_n, den_n, data_oe;
   logic [7:0]        data_out;
   logic [1:0]        grant, ack;
   logic [7:0]        rdata;
   logic              err;

   int checks   = 0;
   int failures = 0;

   bus_cycle_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .req(req),
      .addr0(addr0), .addr1(addr1), .iom0(iom0), .iom1(iom1),
      .wr0(wr0), .wr1(wr1), .wdata0(wdata0), .wdata1(wdata1),
      .ready(ready), .data_in(data_in),
      .bus_addr(bus_addr), .ale(ale), .iom(iom), .rd_n(rd_n), .wr_n(wr_n),
      .den_n(den_n), .data_oe(data_oe), .data_out(data_out),
      .grant(grant), .ack(ack), .rdata(rdata), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed control view: {ale, rd_n, wr_n, den_n, data_oe, grant, ack}
   function automatic logic [8:0] ctl();
      return {ale, rd_n, wr_n, den_n, data_oe, grant, ack};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++;
      if (ctl() !== 9'b0_1_1_1_0_00_00) begin
         failures++;
         $display("FAIL reset_ctl got=%b exp=%b", ctl(), 9'b0_1_1_1_0_00_00);
      end
      checks++;
      if ({bus_addr, data_out, rdata, err, iom} !== '0) begin
         failures++;
         $display("FAIL reset_regs got=%h/%h/%h/%b/%b exp=0", bus_addr, data_out, rdata, err, iom);
      end
      reset = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (ctl() !== 9'b0_1_1_1_0_00_00) begin
         failures++;
         $display("FAIL idle_no_req got=%b exp=%b", ctl(), 9'b0_1_1_1_0_00_00);
      end
   endtask

   task automatic test_single_read();
      logic [8:0] exp_c [5];
      exp_c = '{9'b1_1_1_1_0_01_00, 9'b0_0_1_0_0_01_00, 9'b0_0_1_0_0_01_00,
                9'b0_1_1_1_0_01_01, 9'b0_1_1_1_0_00_00};
      addr0 = 20'hFF03; iom0 = 1'b1; wr0 = 1'b0; wdata0 = 8'h00;
      ready = 1'b1; data_in = 8'h5A; req = 2'b01;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (ctl() !== exp_c[i]) begin
            failures++;
            $display("FAIL read_ctl cyc=%0d got=%b exp=%b", i, ctl(), exp_c[i]);
         end
         if (i == 0) begin
            checks++;
            if ({bus_addr, iom} !== {20'hFF03, 1'b1}) begin
               failures++;
               $display("FAIL read_addr got=%h/%b exp=FF03/1", bus_addr, iom);
            end
         end
         if (i == 3) begin
            checks++;
            if ({rdata, err} !== {8'h5A, 1'b0}) begin
               failures++;
               $display("FAIL read_data got=%h/%b exp=5a/0", rdata, err);
            end
            req = 2'b00;
         end
      end
   endtask

   task automatic test_single_write();
      logic [8:0] exp_c [5];
      exp_c = '{9'b1_1_1_1_0_10_00, 9'b0_1_0_0_1_10_00, 9'b0_1_0_0_1_10_00,
                9'b0_1_1_1_1_10_10, 9'b0_1_1_1_0_00_00};
      addr1 = 20'h01C10; iom1 = 1'b1; wr1 = 1'b1; wdata1 = 8'hA5;
      ready = 1'b1; data_in = 8'hEE; req = 2'b10;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (ctl() !== exp_c[i]) begin
            failures++;
            $display("FAIL write_ctl cyc=%0d got=%b exp=%b", i, ctl(), exp_c[i]);
         end
         if (i == 1) begin
            checks++;
            if ({bus_addr, iom, data_out} !== {20'h01C10, 1'b1, 8'hA5}) begin
               failures++;
               $display("FAIL write_bus got=%h/%b/%h exp=01c10/1/a5", bus_addr, iom, data_out);
            end
         end
         if (i == 3) begin
            checks++;
            if ({rdata, err} !== {8'h5A, 1'b0}) begin
               failures++;
               $display("FAIL write_rdata_hold got=%h/%b exp=5a/0", rdata, err);
            end
            req = 2'b00;
         end
      end
   endtask

   task automatic test_contention();
      logic [1:0] exp_own [4];
      int n;
      exp_own = '{2'b01, 2'b10, 2'b01, 2'b10};
      n = 0;
      addr0 = 20'h00100; addr1 = 20'h00200; iom0 = 1'b0; iom1 = 1'b0;
      wr0 = 1'b0; wr1 = 1'b0; ready = 1'b1; data_in = 8'h66; req = 2'b11;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         tick();
         if (ack != 2'b00) begin
            checks++;
            if (ack !== exp_own[n] || cyc != 4 + 5 * n ||
                bus_addr !== ((exp_own[n] == 2'b01) ? 20'h00100 : 20'h00200)) begin
               failures++;
               $display("FAIL contention n=%0d got ack=%b cyc=%0d addr=%h exp ack=%b cyc=%0d",
                        n, ack, cyc, bus_addr, exp_own[n], 4 + 5 * n);
            end
            n++;
            if (n == 4) begin
               req = 2'b00;
               break;
            end
         end
      end
      checks++;
      if (n != 4) begin
         failures++;
         $display("FAIL contention_count got=%0d exp=4", n);
      end
      tick();
   endtask

   task automatic test_wait_states();
      int ack_cyc;
      ack_cyc = 0;
      addr0 = 20'h12345; wr0 = 1'b0; iom0 = 1'b0;
      ready = 1'b0; data_in = 8'hC3; req = 2'b01;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (k == 4) begin
            checks++;
            if ({rd_n, wr_n, den_n} !== 3'b010) begin
               failures++;
               $display("FAIL wait_strobes got=%b exp=010", {rd_n, wr_n, den_n});
            end
         end
         if (ack != 2'b00) begin
            ack_cyc = k;
            checks++;
            if ({ack, rdata, err} !== {2'b01, 8'hC3, 1'b0}) begin
               failures++;
               $display("FAIL wait_ack got=%b/%h/%b exp=01/c3/0", ack, rdata, err);
            end
            req = 2'b00;
            break;
         end
         ready = (k >= 6);
      end
      checks++;
      if (ack_cyc != 7) begin
         failures++;
         $display("FAIL wait_latency got=%0d exp=7", ack_cyc);
      end
      tick();
   endtask

   task automatic test_timeout();
      int ack_cyc;
      ack_cyc = 0;
      addr1 = 20'h0ABCD; wr1 = 1'b0; iom1 = 1'b1;
      ready = 1'b0; data_in = 8'h99; req = 2'b10;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (ack != 2'b00) begin
            ack_cyc = k;
            checks++;
            if ({ack, rdata, err} !== {2'b10, 8'hC3, 1'b1}) begin
               failures++;
               $display("FAIL timeout_ack got=%b/%h/%b exp=10/c3/1", ack, rdata, err);
            end
            req = 2'b00;
            break;
         end
      end
      checks++;
      if (ack_cyc != 8) begin
         failures++;
         $display("FAIL timeout_latency got=%0d exp=8", ack_cyc);
      end
      tick();
      wr0 = 1'b0; ready = 1'b1; data_in = 8'h11; req = 2'b01;
      tick();
      checks++;
      if ({ale, err} !== 2'b10) begin
         failures++;
         $display("FAIL timeout_err_clear got=%b exp=10", {ale, err});
      end
      tick(); tick(); tick();
      checks++;
      if ({ack, rdata, err} !== {2'b01, 8'h11, 1'b0}) begin
         failures++;
         $display("FAIL after_timeout got=%b/%h/%b exp=01/11/0", ack, rdata, err);
      end
      req = 2'b00;
      tick();
   endtask

   task automatic test_async_reset();
      addr0 = 20'h00777; wr0 = 1'b0; ready = 1'b0; req = 2'b01;
      tick(); tick(); tick(); tick();
      checks++;
      if ({rd_n, den_n, grant} !== 4'b0001) begin
         failures++;
         $display("FAIL pre_reset_tw got=%b exp=0001", {rd_n, den_n, grant});
      end
      reset = 1'b1;
      #1;
      checks++;
      if (ctl() !== 9'b0_1_1_1_0_00_00) begin
         failures++;
         $display("FAIL async_reset_ctl got=%b exp=%b", ctl(), 9'b0_1_1_1_0_00_00);
      end
      checks++;
      if ({bus_addr, data_out, rdata, err, iom} !== '0) begin
         failures++;
         $display("FAIL async_reset_regs got=%h/%h/%h/%b/%b exp=0", bus_addr, data_out, rdata, err, iom);
      end
      tick(); tick();
      req = 2'b11; ready = 1'b1; wr1 = 1'b0;
      reset = 1'b0;
      tick();
      checks++;
      if ({ale, grant} !== 3'b101) begin
         failures++;
         $display("FAIL post_reset_grant got=%b exp=101", {ale, grant});
      end
      req = 2'b00;
      tick(); tick(); tick();
      checks++;
      if (ack !== 2'b01) begin
         failures++;
         $display("FAIL post_reset_ack got=%b exp=01", ack);
      end
      tick();
   endtask

   initial begin
      reset = 1'b1; req = 2'b00;
      addr0 = '0; addr1 = '0; iom0 = 1'b0; iom1 = 1'b0;
      wr0 = 1'b0; wr1 = 1'b0; wdata0 = 8'h00; wdata1 = 8'h00;
      ready = 1'b1; data_in = 8'h00;
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_wait_states();
      test_timeout();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
